// File: rtl/ycbcr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ycbcr_pkg                                              |
// | Description : Shared constants for the RGB->YCbCr pipeline:          |
// |               BT.601/BT.709 coefficient sets, mode encodings and     |
// |               limited-range bounds/scale factors.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ycbcr_pkg;

  // Mode select encodings
  localparam logic c_STD_601       = 1'b0;
  localparam logic c_STD_709       = 1'b1;
  localparam logic c_RANGE_FULL    = 1'b0;
  localparam logic c_RANGE_LIMITED = 1'b1;

  // Coefficients are tabulated at scale 2^10 and rescaled to COEF_FRAC
  localparam int c_COEF_TAB_FRAC = 10;

  // [std][row][col]; rows are Y, Cb, Cr; cols are R, G, B
  localparam int c_COEF [2][3][3] = '{
    '{ '{ 306,  601,  117}, '{-173, -339,  512}, '{ 512, -429,  -83} },
    '{ '{ 218,  732,   74}, '{-117, -395,  512}, '{ 512, -465,  -47} }
  };

  // Limited-range bounds (8-bit units) and scale factors (scale 256)
  localparam int c_LIM_LO    = 16;
  localparam int c_LIM_Y_HI  = 235;
  localparam int c_LIM_C_HI  = 240;
  localparam int c_Y_SCALE   = 220;
  localparam int c_C_SCALE   = 225;

  // Re-express a tabulated coefficient at 2^frac scale
  function automatic int f_scale_coef(input int c, input int frac);
    return (c * (1 << frac)) / (1 << c_COEF_TAB_FRAC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ycbcr_range_scale.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ycbcr_range_scale                                      |
// | Description : Combinational full->limited range mapping for one luma |
// |               and two chroma channels; passthrough in full range.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ycbcr_range_scale
  import ycbcr_pkg::*;
#(
  parameter int DATA_W = 8
)
(
  input  logic              i_range,
  input  logic [DATA_W-1:0] i_y,
  input  logic [DATA_W-1:0] i_cb,
  input  logic [DATA_W-1:0] i_cr,
  output logic [DATA_W-1:0] o_y,
  output logic [DATA_W-1:0] o_cb,
  output logic [DATA_W-1:0] o_cr
);

  localparam int c_K = 1 << (DATA_W - 8);
  localparam int c_W = DATA_W + 10;

  localparam logic signed [c_W-1:0] c_MID  = c_W'(1 << (DATA_W - 1));
  localparam logic signed [c_W-1:0] c_LO   = c_W'(c_LIM_LO * c_K);
  localparam logic signed [c_W-1:0] c_YHI  = c_W'(c_LIM_Y_HI * c_K);
  localparam logic signed [c_W-1:0] c_CHI  = c_W'(c_LIM_C_HI * c_K);
  localparam logic signed [c_W-1:0] c_YS   = c_W'(c_Y_SCALE);
  localparam logic signed [c_W-1:0] c_CS   = c_W'(c_C_SCALE);
  localparam logic signed [c_W-1:0] c_HALF = c_W'(128);

  function automatic logic [DATA_W-1:0] f_clamp(input logic signed [c_W-1:0] v,
                                                input logic signed [c_W-1:0] hi);
    if (v < c_LO) return DATA_W'(c_LO);
    if (v > hi)   return DATA_W'(hi);
    return DATA_W'(v);
  endfunction

  function automatic logic [DATA_W-1:0] f_luma(input logic [DATA_W-1:0] y);
    logic signed [c_W-1:0] t;
    t = $signed(c_W'(y));
    t = ((t * c_YS + c_HALF) >>> 8) + c_LO;
    return f_clamp(t, c_YHI);
  endfunction

  // Chroma is scaled about mid so the neutral point is preserved
  function automatic logic [DATA_W-1:0] f_chroma(input logic [DATA_W-1:0] c);
    logic signed [c_W-1:0] t;
    t = $signed(c_W'(c)) - c_MID;
    t = ((t * c_CS + c_HALF) >>> 8) + c_MID;
    return f_clamp(t, c_CHI);
  endfunction

  // Select passthrough or limited-range mapping
  always_comb begin
    o_y  = i_y;
    o_cb = i_cb;
    o_cr = i_cr;
    if (i_range == c_RANGE_LIMITED) begin
      o_y  = f_luma(i_y);
      o_cb = f_chroma(i_cb);
      o_cr = f_chroma(i_cr);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rgb_to_ycbcr_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rgb_to_ycbcr_pipe                                      |
// | Description : 3-stage RGB->YCbCr converter with valid/ready stream,  |
// |               per-frame standard/range mode and sof/eol sideband.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rgb_to_ycbcr_pipe
  import ycbcr_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int COEF_FRAC = 10
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_r,
  input  logic [DATA_W-1:0] s_g,
  input  logic [DATA_W-1:0] s_b,
  input  logic              s_sof,
  input  logic              s_eol,
  input  logic              std_sel,
  input  logic              range_sel,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_y,
  output logic [DATA_W-1:0] m_cb,
  output logic [DATA_W-1:0] m_cr,
  output logic              m_sof,
  output logic              m_eol
);

  localparam int c_PROD_W = DATA_W + COEF_FRAC + 2;
  localparam int c_SUM_W  = c_PROD_W + 2;

  localparam logic signed [c_SUM_W-1:0] c_ROUND   = c_SUM_W'(1 << (COEF_FRAC - 1));
  localparam logic signed [c_SUM_W-1:0] c_MID_OFS = c_SUM_W'(1 << (DATA_W - 1 + COEF_FRAC));
  localparam logic signed [c_SUM_W-1:0] c_MAX     = c_SUM_W'((1 << DATA_W) - 1);

  logic w_adv, w_accept, w_std, w_rng;
  logic r_std, r_rng;
  logic signed [c_PROD_W-1:0] w_comp [3];
  logic signed [c_PROD_W-1:0] w_prod [3][3];

  // S1 registers
  logic                       r_v1, r_sof1, r_eol1, r_rng1;
  logic signed [c_PROD_W-1:0] r_p1 [3][3];
  // S2 registers
  logic                       r_v2, r_sof2, r_eol2, r_rng2;
  logic [DATA_W-1:0]          r_y2, r_cb2, r_cr2;
  // S3 combinational result
  logic [DATA_W-1:0]          w_y3, w_cb3, w_cr3;

  assign w_adv    = !m_valid || m_ready;
  assign s_ready  = w_adv;
  assign w_accept = s_valid && w_adv;
  // A sof beat uses the mode it carries, not the previously latched one
  assign w_std    = (w_accept && s_sof) ? std_sel   : r_std;
  assign w_rng    = (w_accept && s_sof) ? range_sel : r_rng;

  // Sum, offset, round and clamp one channel back to DATA_W
  function automatic logic [DATA_W-1:0] f_norm(input logic signed [c_PROD_W-1:0] a,
                                               input logic signed [c_PROD_W-1:0] b,
                                               input logic signed [c_PROD_W-1:0] c,
                                               input logic chroma);
    logic signed [c_SUM_W-1:0] s;
    s = c_SUM_W'(a) + c_SUM_W'(b) + c_SUM_W'(c) + c_ROUND;
    if (chroma) s = s + c_MID_OFS;
    s = s >>> COEF_FRAC;
    if (s < 0)     return '0;
    if (s > c_MAX) return '1;
    return DATA_W'(s);
  endfunction

  // Nine component x coefficient products for the S1 register
  always_comb begin
    w_comp[0] = c_PROD_W'($signed({1'b0, s_r}));
    w_comp[1] = c_PROD_W'($signed({1'b0, s_g}));
    w_comp[2] = c_PROD_W'($signed({1'b0, s_b}));
    for (int row = 0; row < 3; row++) begin
      for (int col = 0; col < 3; col++) begin
        w_prod[row][col] = w_comp[col] *
          c_PROD_W'(f_scale_coef(c_COEF[w_std][row][col], COEF_FRAC));
      end
    end
  end

  ycbcr_range_scale #(
    .DATA_W (DATA_W)
  ) u_range (
    .i_range (r_rng2),
    .i_y     (r_y2),
    .i_cb    (r_cb2),
    .i_cr    (r_cr2),
    .o_y     (w_y3),
    .o_cb    (w_cb3),
    .o_cr    (w_cr3)
  );

  // Frame mode register, loaded only on an accepted sof beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_std <= c_STD_709;
      r_rng <= c_RANGE_FULL;
    end else if (w_accept && s_sof) begin
      r_std <= std_sel;
      r_rng <= range_sel;
    end
  end

  // Lock-step pipeline; every stage holds when the output is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0; r_sof1 <= 1'b0; r_eol1 <= 1'b0; r_rng1 <= 1'b0;
      for (int row = 0; row < 3; row++)
        for (int col = 0; col < 3; col++)
          r_p1[row][col] <= '0;
      r_v2 <= 1'b0; r_sof2 <= 1'b0; r_eol2 <= 1'b0; r_rng2 <= 1'b0;
      r_y2 <= '0; r_cb2 <= '0; r_cr2 <= '0;
      m_valid <= 1'b0; m_sof <= 1'b0; m_eol <= 1'b0;
      m_y <= '0; m_cb <= '0; m_cr <= '0;
    end else if (w_adv) begin
      r_v1   <= s_valid;
      r_sof1 <= s_valid && s_sof;
      r_eol1 <= s_valid && s_eol;
      r_rng1 <= w_rng;
      r_p1   <= w_prod;
      r_v2   <= r_v1;
      r_sof2 <= r_sof1;
      r_eol2 <= r_eol1;
      r_rng2 <= r_rng1;
      r_y2   <= f_norm(r_p1[0][0], r_p1[0][1], r_p1[0][2], 1'b0);
      r_cb2  <= f_norm(r_p1[1][0], r_p1[1][1], r_p1[1][2], 1'b1);
      r_cr2  <= f_norm(r_p1[2][0], r_p1[2][1], r_p1[2][2], 1'b1);
      m_valid <= r_v2;
      m_sof   <= r_sof2;
      m_eol   <= r_eol2;
      m_y     <= w_y3;
      m_cb    <= w_cb3;
      m_cr    <= w_cr3;
    end
  end

endmodule
`default_nettype wire

// File: doc/rgb_to_ycbcr_pipe.md
Name: rgb_to_ycbcr_pipe

Overview:
Pipelined, parametrised RGB-to-YCbCr converter with valid/ready stream handshake. It sits between the camera capture/debayer path and the Sobel/HDMI path.
- Colour standard (BT.601/BT.709) and output range (full/limited) are selectable per frame.
- Frame sideband (sof/eol) is carried through alongside the pixel data.
- Fixed latency of 3 accepted-advance cycles; it backpressures the source when the downstream stalls.

Parameters:
DATA_W, 8, component width for input and output; legal range 8..12.
COEF_FRAC, 10, fractional bits of the coefficients (scale 2^COEF_FRAC).

Ports:
clk  in  1  pixel clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
s_valid  in  1  input pixel valid
s_ready  out  1  converter can accept an input pixel
s_r, s_g, s_b  in  DATA_W each  RGB components, unsigned
s_sof  in  1  first pixel of frame
s_eol  in  1  last pixel of line
std_sel  in  1  0 = BT.601, 1 = BT.709; sampled only at sof
range_sel  in  1  0 = full range, 1 = limited range; sampled only at sof
m_valid  out  1  output pixel valid
m_ready  in  1  downstream accepts the output pixel
m_y, m_cb, m_cr  out  DATA_W each  YCbCr components
m_sof, m_eol  out  1  sideband, delayed with its pixel

Behaviour:
Reset:
- All stage valid bits are 0.
- m_valid, m_sof, m_eol, m_y, m_cb and m_cr are 0.
- The mode register resets to std = 1 (709) and range = 0 (full).
- Reset asserted mid-frame discards all in-flight pixels on the next edge. Nothing is flushed.

Handshake:
- advance = !m_valid || m_ready; s_ready = advance.
- When advance is high, all three stages shift together.
- An input is accepted when s_valid && s_ready. When s_valid is low, a bubble (valid = 0) enters S1.
- Bubbles are not compressed.
- When advance is low, every stage register, including the outputs, holds its value unchanged.
- The m_* outputs never change while m_valid && !m_ready.

Latency:
- An accepted pixel appears on m_* after exactly 3 advancing cycles.
- With m_ready tied high, the output follows the input 3 clocks later.

Mode:
- On an accepted beat with s_sof = 1, std_sel and range_sel are loaded into the mode register. That same beat uses the new values.
- Every pixel captures the mode bits it was accepted with, and those bits travel down the pipe with it.
- Pixels of the previous frame that are still in flight finish with their own mode.
- Toggling the mode inputs without sof has no effect.

Coefficient sets (scale 1024, signed; each Y row sums to 1024, each C row sums to 0):
- 709: Y (218, 732, 74); Cb (-117, -395, 512); Cr (512, -465, -47).
- 601: Y (306, 601, 117); Cb (-173, -339, 512); Cr (512, -429, -83).

Stage S1: nine signed products, component × coefficient, each DATA_W+COEF_FRAC+2 bits wide.

Stage S2, full range, per channel:
- Sum the three products.
- Chroma channels add mid << COEF_FRAC, where mid = 2^(DATA_W-1).
- Add 2^(COEF_FRAC-1) for round-half-up, then arithmetic-shift right by COEF_FRAC.
- Clamp to [0, 2^DATA_W - 1].

Stage S3, range mapping:
- Let k = 2^(DATA_W-8).
- range = 0: pass the full-range values through unchanged.
- range = 1, luma: Y = 16k + ((Yf*220 + 128) >> 8), then clamp to [16k, 235k].
- range = 1, chroma: C = mid + ((Cf - mid)*225 + 128) >>> 8 (signed), then clamp to [16k, 240k].
- The output registers are loaded at the end of S3.

Sideband: sof/eol shift with valid in all stages. Bubbles carry sof = eol = 0.

Decomposition:
Package ycbcr_pkg holds:
- The 601/709 coefficient constants, as arrays indexed by std.
- Named constants for std_sel and range_sel values.
- The limited-range bounds 16/235/240 and the scale factors 220/225.

Sub-module ycbcr_range_scale implements the combinational S3 mapping for one luma plus two chroma channels, parametrised by DATA_W. The top module owns the handshake, the stage registers and the mode tracking.

Test Plan:
1. White (255,255,255), 709 full, m_ready = 1 -> (255,128,128) exactly 3 clocks after acceptance; with limited range -> (235,128,128).
2. Black (0,0,0) in limited mode -> (16,128,128). Red (255,0,0) gives:
   - 709 full -> (54,99,255).
   - 601 full -> (76,85,255).
   - 709 limited -> (62,103,240).
3. Stream 6 pixels and hold m_ready low from cycle 4 for 5 cycles:
   - s_ready falls once the pipe is full.
   - m_* stays stable while stalled.
   - All 6 pixels arrive in order with none lost or duplicated.
4. Frame 1 in 709 full, then toggle std_sel/range_sel mid-frame -> no change. Frame 2 sof with 601 limited:
   - The last 709 pixels still in flight come out 709 full.
   - The first pixel of frame 2 comes out 601 limited.
5. Assert rst for 1 cycle with 3 pixels in flight -> next cycle m_valid = 0 and all outputs are 0; the mode returns to 709 full.
6. Random RGB with random s_valid/m_ready, DATA_W = 8 and DATA_W = 10 -> outputs match the integer reference model bit-exactly; sof/eol stay aligned with their pixels.
